seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider that performs the inverse of the adder/subtractor datapath: it divides a dividend by a divisor one bit per clock. Each iteration uses a subtract-and-restore step. The block sits beside the ALU as a long-latency functional unit. It uses a start/done handshake, and the issuing logic must wait for `done`.

---
 rtl/div_pkg.sv | 12 +
 rtl/seq_divider_if.sv | 23 ++
 rtl/addsub_nbit.sv | 39 +++
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and defaults for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/done request and result bundle for seq_divider
interface seq_divider_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/addsub_nbit.sv
// rtl/addsub_nbit.sv - ripple-carry adder/subtractor built from 1-bit full adders
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0]   carry;
    logic [N-1:0] b_x;

    // Two's complement subtract: invert b and inject the +1 as carry-in.
    assign b_x      = b ^ {N{sub}};
    assign carry[0] = sub;
    assign cout     = carry[N];

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder_1bit u_fa (
            .a   (a[i]),
            .b   (b_x[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .cout(carry[i+1])
        );
    end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state, state_next;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             div_zero_r;

    logic             load, iter, finish_run, finish_zero, last;
    logic [WIDTH:0]   rem_sh, trial, rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             no_borrow;

    assign rem_sh = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    assign last   = (cnt == CW'(WIDTH - 1));

    addsub_nbit #(.N(WIDTH + 1)) u_trial (
        .a   (rem_sh),
        .b   ({1'b0, dvs_r}),
        .sub (1'b1),
        .sum (trial),
        .cout(no_borrow)
    );

    // Partial remainder stays below 2*divisor, so the carry-out is exactly ~trial[WIDTH].
    assign rem_nx = no_borrow ? trial : rem_sh;
    assign quo_nx = {quo_r[WIDTH-2:0], no_borrow};

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        iter        = 1'b0;
        finish_run  = 1'b0;
        finish_zero = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_next  = DONE;
                        finish_zero = 1'b1;
                    end else begin
                        state_next = RUN;
                        load       = 1'b1;
                    end
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                iter = 1'b1;
                if (last) begin
                    state_next = DONE;
                    finish_run = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_r       <= '0;
            rem_r       <= '0;
            dvs_r       <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
        end else begin
            if (load) begin
                quo_r      <= bus.dividend;
                rem_r      <= '0;
                dvs_r      <= bus.divisor;
                cnt        <= '0;
                div_zero_r <= 1'b0;
            end
            if (iter) begin
                quo_r <= quo_nx;
                rem_r <= rem_nx;
                cnt   <= cnt + 1'b1;
            end
            if (finish_run) begin
                quotient_r  <= quo_nx;
                remainder_r <= rem_nx[WIDTH-1:0];
            end
            if (finish_zero) begin
                quotient_r  <= '1;
                remainder_r <= bus.dividend;
                div_zero_r  <= 1'b1;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed vector bench for seq_divider
module tb_seq_divider;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    seq_divider_if #(.WIDTH(4)) dif ();

    seq_divider #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         q;
        int         r;
        int         dz;
        int         lat;
        int         bsy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output int lat, output int busy_cycles, output int overlap);
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
        @(negedge clk);
        dif.start = 1'b0;
        lat = 1; busy_cycles = 0; overlap = 0;
        while (!dif.done && lat < 20) begin
            if (dif.busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (dif.busy && dif.done) overlap = 1;
    endtask

    initial begin
        int lat, bc, ov, ndone, n1, n2, q1, r1, q2, r2;

        vecs[0] = '{4'd13, 4'd4,  3,  1, 0, 5, 4};
        vecs[1] = '{4'd15, 4'd1,  15, 0, 0, 5, 4};
        vecs[2] = '{4'd3,  4'd9,  0,  3, 0, 5, 4};
        vecs[3] = '{4'd7,  4'd0,  15, 7, 1, 1, 0};
        vecs[4] = '{4'd0,  4'd5,  0,  0, 0, 5, 4};
        vecs[5] = '{4'd15, 4'd15, 1,  0, 0, 5, 4};
        vecs[6] = '{4'd9,  4'd2,  4,  1, 0, 5, 4};
        vecs[7] = '{4'd1,  4'd15, 0,  1, 0, 5, 4};
        vecs[8] = '{4'd15, 4'd0,  15, 15, 1, 1, 0};
        vecs[9] = '{4'd14, 4'd3,  4,  2, 0, 5, 4};

        dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", dif.busy, 0);
        check("reset_done", dif.done, 0);
        check("reset_quotient", dif.quotient, 0);
        check("reset_remainder", dif.remainder, 0);
        check("reset_div_zero", dif.div_zero, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bc, ov);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].bsy);
            check($sformatf("v%0d_busy_done_overlap", i), ov, 0);
            check($sformatf("v%0d_quotient", i), dif.quotient, vecs[i].q);
            check($sformatf("v%0d_remainder", i), dif.remainder, vecs[i].r);
            check($sformatf("v%0d_div_zero", i), dif.div_zero, vecs[i].dz);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), dif.done, 0);
            check($sformatf("v%0d_quotient_held", i), dif.quotient, vecs[i].q);
        end

        // start pulsed mid-RUN with different operands must be ignored
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd12; dif.divisor = 4'd5;
        ndone = 0; n1 = 0; q1 = 0; r1 = 0; ov = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (dif.done) begin
                ndone++;
                if (n1 == 0) begin n1 = n; q1 = dif.quotient; r1 = dif.remainder; end
            end
            if (dif.busy && dif.done) ov = 1;
            dif.start    = (n == 2);
            dif.dividend = (n == 2) ? 4'd9 : 4'd0;
            dif.divisor  = (n == 2) ? 4'd3 : 4'd0;
        end
        check("ignore_done_count", ndone, 1);
        check("ignore_latency", n1, 5);
        check("ignore_quotient", q1, 2);
        check("ignore_remainder", r1, 2);
        check("ignore_overlap", ov, 0);

        // asynchronous reset in the 2nd RUN cycle discards the operation
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd14; dif.divisor = 4'd3;
        @(negedge clk);
        dif.start = 1'b0;
        check("midrst_busy_before", dif.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", dif.busy, 0);
        check("midrst_done", dif.done, 0);
        check("midrst_quotient", dif.quotient, 0);
        check("midrst_remainder", dif.remainder, 0);
        check("midrst_div_zero", dif.div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (dif.done || dif.busy) ndone++;
        end
        check("midrst_no_activity", ndone, 0);
        run_op(4'd14, 4'd3, lat, bc, ov);
        check("after_rst_latency", lat, 5);
        check("after_rst_quotient", dif.quotient, 4);
        check("after_rst_remainder", dif.remainder, 2);

        // start held high: second request accepted in the DONE cycle
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd10; dif.divisor = 4'd3;
        ndone = 0; n1 = 0; n2 = 0; q1 = 0; r1 = 0; q2 = 0; r2 = 0; ov = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (dif.busy && dif.done) ov = 1;
            if (dif.done) begin
                ndone++;
                if (n1 == 0) begin
                    n1 = n; q1 = dif.quotient; r1 = dif.remainder;
                    dif.dividend = 4'd8; dif.divisor = 4'd2;
                end else if (n2 == 0) begin
                    n2 = n; q2 = dif.quotient; r2 = dif.remainder;
                end
            end else if (n1 != 0) begin
                dif.start = 1'b0;
            end
        end
        check("b2b_done_count", ndone, 2);
        check("b2b_first_latency", n1, 5);
        check("b2b_spacing", n2 - n1, 5);
        check("b2b_q1", q1, 3);
        check("b2b_r1", r1, 1);
        check("b2b_q2", q2, 4);
        check("b2b_r2", r2, 0);
        check("b2b_overlap", ov, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
